ps2_kbd_rx: RTL and testbench

//  PS/2 keyboard receiver and scancode decoder. Produces the ps2_valid/ps2_data pair consumed by game_logic.

---
 rtl/pacman_pkg.sv | 26 ++
 rtl/ps2_kbd_rx_if.sv | 33 +++
 rtl/ps2_frame_rx.sv | 121 ++++++++++++
 rtl/ps2_kbd_rx.sv | 93 +++++++++
 tb/tb_ps2_kbd_rx.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_pkg.sv
// Shared constants for the PS/2 keyboard path and game_logic.
// Also holds the frame FSM state type and byte classification helper.
package pacman_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_ACK   = 8'hFA;
   localparam logic [7:0] PS2_BAT   = 8'hAA;
   localparam logic [7:0] PS2_ECHO  = 8'hEE;

   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_STOP
   } frame_st_e;

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO);
   endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Keyboard line inputs and decoded key outputs of ps2_kbd_rx.
// master = receiver side, slave = keyboard model / consumer side.
interface ps2_kbd_rx_if;

   logic       ps2_clk_i;
   logic       ps2_dat_i;
   logic       ps2_valid;
   logic [7:0] ps2_data;
   logic       ps2_ext_o;
   logic       key_stb_o;
   logic       frame_err_o;

   modport master (
      input  ps2_clk_i,
      input  ps2_dat_i,
      output ps2_valid,
      output ps2_data,
      output ps2_ext_o,
      output key_stb_o,
      output frame_err_o
   );

   modport slave (
      output ps2_clk_i,
      output ps2_dat_i,
      input  ps2_valid,
      input  ps2_data,
      input  ps2_ext_o,
      input  key_stb_o,
      input  frame_err_o
   );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, clock glitch filter and 11-bit frame receiver.
// Emits one byte strobe per good frame, one error strobe per bad or stalled frame.
module ps2_frame_rx
   import pacman_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic [7:0] byte_o,
   output logic       byte_stb_o,
   output logic       err_o
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

   logic [SYNC_STAGES-1:0] csync_q, dsync_q;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic                   filt_q, filt_d;
   logic                   fe_q, fe_d;
   logic                   cs, ds;

   frame_st_e     st_q;
   logic [3:0]    bit_q;
   logic [8:0]    sr_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    byte_q;
   logic          stb_q, err_q;
   logic          good;

   assign cs = csync_q[SYNC_STAGES-1];
   assign ds = dsync_q[SYNC_STAGES-1];

   // Filtered level flips only after FILTER_LEN samples that all disagree with it
   always_comb begin
      fcnt_d = '0;
      filt_d = filt_q;
      fe_d   = 1'b0;
      if (cs != filt_q) begin
         if (fcnt_q == FMAX) begin
            filt_d = cs;
            fe_d   = ~cs;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         csync_q <= '0;
         dsync_q <= '0;
         fcnt_q  <= '0;
         filt_q  <= 1'b1;
         fe_q    <= 1'b0;
      end else begin
         csync_q <= {csync_q[SYNC_STAGES-2:0], ps2_clk_i};
         dsync_q <= {dsync_q[SYNC_STAGES-2:0], ps2_dat_i};
         fcnt_q  <= fcnt_d;
         filt_q  <= filt_d;
         fe_q    <= fe_d;
      end
   end

   // Stop bit high and odd parity over data+parity
   assign good = ds & (^sr_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= ST_IDLE;
         bit_q  <= '0;
         sr_q   <= '0;
         tmo_q  <= '0;
         byte_q <= '0;
         stb_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         stb_q <= 1'b0;
         err_q <= 1'b0;
         if ((st_q == ST_IDLE) || fe_q) tmo_q <= '0;
         else                           tmo_q <= tmo_q + 1'b1;
         if (fe_q) begin
            unique case (st_q)
               ST_IDLE: begin
                  if (!ds) begin
                     st_q  <= ST_SHIFT;
                     bit_q <= '0;
                  end
               end
               ST_SHIFT: begin
                  sr_q <= {ds, sr_q[8:1]};
                  if (bit_q == 4'd8) st_q  <= ST_STOP;
                  else               bit_q <= bit_q + 1'b1;
               end
               ST_STOP: begin
                  byte_q <= sr_q[7:0];
                  stb_q  <= good;
                  err_q  <= ~good;
                  st_q   <= ST_IDLE;
               end
               default: st_q <= ST_IDLE;
            endcase
         end else if ((st_q != ST_IDLE) && (tmo_q == TMAX)) begin
            err_q <= 1'b1;
            st_q  <= ST_IDLE;
         end
      end
   end

   assign byte_o     = byte_q;
   assign byte_stb_o = stb_q;
   assign err_o      = err_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame reception plus E0/F0 scancode decoding.
// Tracks the most recently pressed key as a held level for game_logic.
module ps2_kbd_rx
   import pacman_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic         clk,
   input  logic         rst,
   ps2_kbd_rx_if.master bus
);

   logic [7:0] byte_w;
   logic       byte_stb_w;
   logic       err_w;

   ps2_frame_rx #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_frame (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk_i (bus.ps2_clk_i),
      .ps2_dat_i (bus.ps2_dat_i),
      .byte_o    (byte_w),
      .byte_stb_o(byte_stb_w),
      .err_o     (err_w)
   );

   logic       ext_q, brk_q;
   logic       valid_q, pext_q;
   logic [7:0] data_q;
   logic       stb_q, ferr_q;
   logic       is_ext, is_brk, is_ign, is_code, rel_hit;

   always_comb begin
      is_ext  = (byte_w == PS2_EXT);
      is_brk  = (byte_w == PS2_BRK);
      is_ign  = is_ignored(byte_w);
      is_code = ~(is_ext | is_brk | is_ign);
      rel_hit = ({ext_q, byte_w} == {pext_q, data_q});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         valid_q <= 1'b0;
         pext_q  <= 1'b0;
         data_q  <= '0;
         stb_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         stb_q  <= 1'b0;
         ferr_q <= err_w;
         if (err_w) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (byte_stb_w) begin
            unique case (1'b1)
               is_ext: ext_q <= 1'b1;
               is_brk: brk_q <= 1'b1;
               is_ign: ;
               is_code && brk_q: begin
                  // Only a release of the displayed key drops the level
                  if (rel_hit) valid_q <= 1'b0;
                  ext_q <= 1'b0;
                  brk_q <= 1'b0;
               end
               is_code && !brk_q: begin
                  data_q  <= byte_w;
                  pext_q  <= ext_q;
                  valid_q <= 1'b1;
                  stb_q   <= 1'b1;
                  ext_q   <= 1'b0;
                  brk_q   <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ps2_valid   = valid_q;
   assign bus.ps2_data    = data_q;
   assign bus.ps2_ext_o   = pext_q;
   assign bus.key_stb_o   = stb_q;
   assign bus.frame_err_o = ferr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: keyboard line model, scancode reference model
// and an event scoreboard drained by an output monitor.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
   import pacman_pkg::*;

   localparam int  TMO  = 600;
   localparam time TCLK = 2000;
   localparam time Q    = 20000;

   localparam int EV_MAKE = 0;
   localparam int EV_REL  = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int         kind;
      logic [7:0] d;
      logic       e;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ps2_kbd_rx_if bus();

   ps2_kbd_rx #(
      .SYNC_STAGES(2),
      .FILTER_LEN (8),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #(TCLK/2) clk = ~clk;

   int checks = 0;
   int errors = 0;
   ev_t exp_q[$];

   // Reference model: held key plus pending prefix flags
   logic       m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   logic       m_ext   = 1'b0;
   logic       p_ext   = 1'b0;
   logic       p_brk   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_ev(input int k, input logic [7:0] d, input logic e);
      ev_t ev;
      ev.kind = k;
      ev.d    = d;
      ev.e    = e;
      exp_q.push_back(ev);
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == PS2_EXT) p_ext = 1'b1;
      else if (b == PS2_BRK) p_brk = 1'b1;
      else if (b == PS2_ACK || b == PS2_BAT || b == PS2_ECHO) begin
      end else if (p_brk) begin
         if (m_valid && p_ext == m_ext && b == m_data) begin
            m_valid = 1'b0;
            push_ev(EV_REL, m_data, m_ext);
         end
         p_ext = 1'b0;
         p_brk = 1'b0;
      end else begin
         m_data  = b;
         m_ext   = p_ext;
         m_valid = 1'b1;
         push_ev(EV_MAKE, b, p_ext);
         p_ext = 1'b0;
         p_brk = 1'b0;
      end
   endtask

   task automatic model_err();
      push_ev(EV_ERR, m_data, m_ext);
      p_ext = 1'b0;
      p_brk = 1'b0;
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b,
                                      input logic pflip,
                                      input logic stop);
      return {stop, (~^b) ^ pflip, b, 1'b0};
   endfunction

   // Bits change mid-high; optional 1-cycle glitches in both clock phases
   task automatic send_bits(input logic [10:0] f, input int n,
                            input bit glitch);
      for (int i = 0; i < n; i++) begin
         #Q;
         bus.ps2_dat_i = f[i];
         if (glitch) begin
            #(Q/2);
            bus.ps2_clk_i = 1'b0;
            #(TCLK);
            bus.ps2_clk_i = 1'b1;
            #(Q/2 - TCLK);
         end else begin
            #Q;
         end
         bus.ps2_clk_i = 1'b0;
         if (glitch) begin
            #Q;
            bus.ps2_clk_i = 1'b1;
            #(TCLK);
            bus.ps2_clk_i = 1'b0;
            #(Q - TCLK);
         end else begin
            #(2*Q);
         end
         bus.ps2_clk_i = 1'b1;
      end
   endtask

   task automatic send_byte_g(input logic [7:0] b, input bit glitch);
      model_byte(b);
      send_bits(mk(b, 1'b0, 1'b1), 11, glitch);
      bus.ps2_dat_i = 1'b1;
      #(2*Q);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_byte_g(b, 1'b0);
   endtask

   task automatic send_bad(input logic [7:0] b, input logic pflip,
                           input logic stop);
      model_err();
      send_bits(mk(b, pflip, stop), 11, 1'b0);
      bus.ps2_dat_i = 1'b1;
      #(2*Q);
   endtask

   task automatic check_levels(input string nm);
      chk({nm, "_valid"}, bus.ps2_valid, m_valid);
      chk({nm, "_data"},  bus.ps2_data,  m_data);
      chk({nm, "_ext"},   bus.ps2_ext_o, m_ext);
   endtask

   task automatic sb_pop(input int kind);
      ev_t ev;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected: got event %0d expected none", kind);
         return;
      end
      ev = exp_q.pop_front();
      chk("sb_kind", kind, ev.kind);
      if (kind != EV_ERR) chk("sb_data", bus.ps2_data, ev.d);
      if (kind == EV_MAKE) begin
         chk("sb_ext", bus.ps2_ext_o, ev.e);
         chk("sb_valid", bus.ps2_valid, 1);
      end
   endtask

   logic vprev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         vprev = 1'b0;
      end else begin
         if (bus.key_stb_o)   sb_pop(EV_MAKE);
         if (bus.frame_err_o) sb_pop(EV_ERR);
         if (vprev && !bus.ps2_valid) sb_pop(EV_REL);
         vprev = bus.ps2_valid;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", bus.ps2_valid,   0);
      chk("rst_data",  bus.ps2_data,    0);
      chk("rst_ext",   bus.ps2_ext_o,   0);
      chk("rst_stb",   bus.key_stb_o,   0);
      chk("rst_err",   bus.frame_err_o, 0);
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ext   = 1'b0;
      p_ext   = 1'b0;
      p_brk   = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [7:0] keys [6];
   logic [7:0] ctls [3];

   initial begin
      logic [7:0] k;
      bit         ex;
      keys = '{KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, 8'h1C, 8'h29};
      ctls = '{PS2_ACK, PS2_BAT, PS2_ECHO};
      bus.ps2_clk_i = 1'b1;
      bus.ps2_dat_i = 1'b1;
      do_reset();
      #(4*Q);

      send_byte(KEY_UP);
      check_levels("t1_make");
      send_byte(PS2_BRK);
      send_byte(KEY_UP);
      check_levels("t1_break");

      send_byte(PS2_EXT);
      send_byte(KEY_RIGHT);
      check_levels("t2_make");
      send_byte(PS2_EXT);
      send_byte(PS2_BRK);
      send_byte(KEY_RIGHT);
      check_levels("t2_break");

      send_bad(KEY_LEFT, 1'b1, 1'b1);
      check_levels("t3_parity");
      send_bad(KEY_DOWN, 1'b0, 1'b0);
      check_levels("t3_stop");

      model_err();
      send_bits(mk(KEY_DOWN, 1'b0, 1'b1), 5, 1'b0);
      bus.ps2_dat_i = 1'b1;
      repeat (2*TMO) @(posedge clk);
      chk("t4_tmo_seen", exp_q.size(), 0);
      send_byte(KEY_DOWN);
      check_levels("t4_after");

      send_byte(KEY_UP);
      send_byte(KEY_LEFT);
      check_levels("t5_override");
      send_byte(PS2_BRK);
      send_byte(KEY_UP);
      check_levels("t5_old_break");
      repeat (3) send_byte(KEY_LEFT);
      check_levels("t5_repeat");
      send_byte(PS2_BRK);
      send_bad(KEY_LEFT, 1'b1, 1'b1);
      send_byte(KEY_UP);
      check_levels("t5_lost_break");

      send_byte_g(KEY_RIGHT, 1'b1);
      check_levels("t6_glitch");
      send_bits(mk(KEY_LEFT, 1'b0, 1'b1), 5, 1'b0);
      bus.ps2_dat_i = 1'b1;
      do_reset();
      repeat (2*TMO) @(posedge clk);
      check_levels("t6_rst");
      send_byte(KEY_UP);
      check_levels("t6_clean");

      for (int n = 0; n < 24; n++) begin
         k  = keys[$urandom_range(0, 5)];
         ex = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               if (ex) send_byte(PS2_EXT);
               send_byte(k);
            end
            4, 5: begin
               if (m_ext) send_byte(PS2_EXT);
               send_byte(PS2_BRK);
               send_byte(m_data);
            end
            6: begin
               if (ex) send_byte(PS2_EXT);
               send_byte(PS2_BRK);
               send_byte(k);
            end
            7: send_bad(k, 1'b1, 1'b1);
            8: send_byte(ctls[$urandom_range(0, 2)]);
            default: begin
               send_byte(PS2_EXT);
               send_bad(k, 1'b0, 1'b0);
               send_byte(k);
            end
         endcase
         check_levels("rand");
      end

      #(4*Q);
      chk("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
